bcd_down_timer: RTL and testbench

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

---
 rtl/bcd_down_timer.sv | 177 +++++++++++++++++
 tb/tb_bcd_down_timer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_down_timer.sv
// Four-digit BCD countdown timer with an IDLE/RUN/PAUSED/DONE control FSM.
// Define BCD_TIMER_AUTORELOAD_EN to reload the last loaded value on reaching 0000.
module bcd_down_timer #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load_enable,
  input  logic [15:0] load,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] count,
  output logic        running,
  output logic        done,
  output logic        zero_pulse
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [PW-1:0] r_prescaler;
  logic [PW-1:0] w_next_prescaler;
  logic [15:0]   r_count;
  logic [15:0]   w_next_count;
  logic [15:0]   w_load_clamped;
  logic [15:0]   w_count_dec;
  logic          w_wrap;
  logic          w_zero_hit;
  logic          r_running;
  logic          r_done;
  logic          r_zero_pulse;

`ifdef BCD_TIMER_AUTORELOAD_EN
  logic [15:0]   r_reload;
`endif

  // Any nibble above 9 is not a legal BCD digit; saturate it to 9.
  function automatic logic [15:0] bcd_clamp(input logic [15:0] value);
    logic [15:0] result;
    result = value;
    for (int i = 0; i < 4; i++) begin
      if (value[i*4 +: 4] > 4'd9) begin
        result[i*4 +: 4] = 4'd9;
      end
    end
    return result;
  endfunction

  // One BCD step down: a zero digit becomes 9 and borrows from the next digit.
  function automatic logic [15:0] bcd_decrement(input logic [15:0] value);
    logic [15:0] result;
    logic        borrow;
    result = value;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (value[i*4 +: 4] == 4'd0) begin
          result[i*4 +: 4] = 4'd9;
        end else begin
          result[i*4 +: 4] = value[i*4 +: 4] - 4'd1;
          borrow           = 1'b0;
        end
      end
    end
    return result;
  endfunction

  assign w_load_clamped = bcd_clamp(load);
  assign w_count_dec    = bcd_decrement(r_count);
  assign w_wrap         = (r_prescaler == PRESC_LAST);

  // NOTE: every signal driven here gets a default first so no path through the
  // case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state     = r_state;
    w_next_prescaler = r_prescaler;
    w_next_count     = r_count;
    w_zero_hit       = 1'b0;

    if (load_enable) begin
      w_next_state     = ST_IDLE;
      w_next_count     = w_load_clamped;
      w_next_prescaler = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !pause && (r_count != 16'h0000)) begin
            w_next_state = ST_RUN;
          end
        end

        ST_RUN: begin
          // The edge that samples pause still counts as a running cycle.
          w_next_prescaler = w_wrap ? '0 : r_prescaler + PW'(1);
          if (w_wrap) begin
            w_next_count = w_count_dec;
            w_zero_hit   = (w_count_dec == 16'h0000);
          end

          if (w_zero_hit) begin
`ifdef BCD_TIMER_AUTORELOAD_EN
            w_next_count = r_reload;
            if (r_reload == 16'h0000) begin
              w_next_state = ST_DONE;
            end else if (pause) begin
              w_next_state = ST_PAUSED;
            end
`else
            w_next_state = ST_DONE;
`endif
          end else if (pause) begin
            w_next_state = ST_PAUSED;
          end
        end

        ST_PAUSED: begin
          if (start && !pause) begin
            w_next_state = ST_RUN;
          end
        end

        ST_DONE: begin
          w_next_state = ST_DONE;
        end

        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_prescaler  <= '0;
      r_count      <= 16'h0000;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_zero_pulse <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_prescaler  <= w_next_prescaler;
      r_count      <= w_next_count;
      r_running    <= (w_next_state == ST_RUN);
      r_done       <= (w_next_state == ST_DONE);
      r_zero_pulse <= w_zero_hit;
    end
  end

`ifdef BCD_TIMER_AUTORELOAD_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_reload <= 16'h0000;
    end else if (load_enable) begin
      r_reload <= w_load_clamped;
    end
  end
`endif

  assign count      = r_count;
  assign running    = r_running;
  assign done       = r_done;
  assign zero_pulse = r_zero_pulse;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer: directed scenarios plus random stimulus,
// compared each cycle against a decimal-arithmetic reference model.
module tb_bcd_down_timer;

  localparam int unsigned TICK_DIV = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        load_enable;
  logic [15:0] load;
  logic        start;
  logic        pause;
  logic [15:0] count;
  logic        running;
  logic        done;
  logic        zero_pulse;

  int n_eval = 0;
  int n_fail = 0;

  typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_DONE} phase_t;

  phase_t m_phase;
  int     m_val;
  int     m_ticks;
  int     m_reload;
  bit     m_zp;

  bcd_down_timer #(.TICK_DIV(TICK_DIV)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_enable (load_enable),
    .load        (load),
    .start       (start),
    .pause       (pause),
    .count       (count),
    .running     (running),
    .done        (done),
    .zero_pulse  (zero_pulse)
  );

  always #5 clock = ~clock;

  function automatic int clamp_val(input logic [15:0] ld);
    int v;
    int d;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(ld[i*4 +: 4]);
      v = v * 10 + ((d > 9) ? 9 : d);
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = M_IDLE;
    m_val    = 0;
    m_ticks  = 0;
    m_reload = 0;
    m_zp     = 1'b0;
  endtask

  task automatic model_edge(input logic le, input logic [15:0] ld, input logic st, input logic ps);
    m_zp = 1'b0;
    if (le) begin
      m_val    = clamp_val(ld);
      m_reload = m_val;
      m_ticks  = 0;
      m_phase  = M_IDLE;
    end else begin
      case (m_phase)
        M_IDLE:   if (st && !ps && m_val != 0) m_phase = M_RUN;
        M_PAUSED: if (st && !ps) m_phase = M_RUN;
        M_RUN: begin
          m_ticks++;
          if (m_ticks == TICK_DIV) begin
            m_ticks = 0;
            m_val   = m_val - 1;
            if (m_val == 0) m_zp = 1'b1;
          end
          if (m_zp) begin
`ifdef BCD_TIMER_AUTORELOAD_EN
            m_val = m_reload;
            if (m_reload == 0) m_phase = M_DONE;
            else if (ps) m_phase = M_PAUSED;
`else
            m_phase = M_DONE;
`endif
          end else if (ps) begin
            m_phase = M_PAUSED;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"},      count,           to_bcd(m_val));
    check({tag, ".running"},    16'(running),    16'(m_phase == M_RUN));
    check({tag, ".done"},       16'(done),       16'(m_phase == M_DONE));
    check({tag, ".zero_pulse"}, 16'(zero_pulse), 16'(m_zp));
  endtask

  task automatic step(input logic le, input logic [15:0] ld, input logic st,
                      input logic ps, input string tag);
    @(negedge clock);
    load_enable = le;
    load        = ld;
    start       = st;
    pause       = ps;
    @(posedge clock);
    model_edge(le, ld, st, ps);
    #1;
    check_model(tag);
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) step(1'b0, 16'h0000, 1'b0, 1'b0, tag);
  endtask

  initial begin
    reset_n     = 1'b0;
    load_enable = 1'b0;
    load        = 16'h0000;
    start       = 1'b0;
    pause       = 1'b0;
    model_reset();
    #12;
    check_model("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // First decrement TICK_DIV cycles after entering RUN, with a borrow chain.
    step(1'b1, 16'h0100, 1'b0, 1'b0, "load0100");
    check("load0100.const", count, 16'h0100);
    step(1'b0, 16'h0000, 1'b1, 1'b0, "start0100");
    idle(4, "run0100");
    check("first_dec.const", count, 16'h0099);
    idle(4, "run0099");
    check("second_dec.const", count, 16'h0098);

`ifndef BCD_TIMER_AUTORELOAD_EN
    // Countdown to zero, DONE held, start ignored.
    step(1'b1, 16'h0002, 1'b0, 1'b0, "load0002");
    step(1'b0, 16'h0000, 1'b1, 1'b0, "start0002");
    idle(4, "run0002");
    check("to0001.const", count, 16'h0001);
    idle(4, "run0001");
    check("to0000.const", count, 16'h0000);
    check("zp_high.const", 16'(zero_pulse), 16'h0001);
    check("done_high.const", 16'(done), 16'h0001);
    idle(1, "done_hold");
    check("zp_low.const", 16'(zero_pulse), 16'h0000);
    step(1'b0, 16'h0000, 1'b1, 1'b0, "done_start");
    step(1'b0, 16'h0000, 1'b1, 1'b1, "done_pause");
    check("done_count.const", count, 16'h0000);
    check("done_still.const", 16'(done), 16'h0001);
`else
    // Auto-reload: zero fires the pulse and reloads on the same edge.
    step(1'b1, 16'h0002, 1'b0, 1'b0, "load0002");
    step(1'b0, 16'h0000, 1'b1, 1'b0, "start0002");
    idle(4, "run0002");
    check("to0001.const", count, 16'h0001);
    idle(4, "run0001");
    check("reload.const", count, 16'h0002);
    check("zp_high.const", 16'(zero_pulse), 16'h0001);
    check("run_stays.const", 16'(running), 16'h0001);
    check("done_low.const", 16'(done), 16'h0000);
    idle(1, "after_reload");
    check("zp_low.const", 16'(zero_pulse), 16'h0000);
`endif

    // Start with count 0000 is ignored.
    step(1'b1, 16'h0000, 1'b0, 1'b0, "load0000");
    step(1'b0, 16'h0000, 1'b1, 1'b0, "start_zero");
    check("start_zero.const", 16'(running), 16'h0000);

    // Pause freezes count and prescaler; resume uses remaining prescaler cycles.
    step(1'b1, 16'h0050, 1'b0, 1'b0, "load0050");
    step(1'b0, 16'h0000, 1'b1, 1'b0, "start0050");
    idle(6, "run0050");
    repeat (20) step(1'b0, 16'h0000, 1'b0, 1'b1, "paused");
    check("paused_frozen.const", count, 16'h0049);
    step(1'b0, 16'h0000, 1'b1, 1'b1, "pause_beats_start");
    step(1'b0, 16'h0000, 1'b1, 1'b0, "resume");
    check("resume_hold.const", count, 16'h0049);
    idle(1, "resume_run");
    check("resume_dec.const", count, 16'h0048);
    // Pause on the wrap edge still takes that decrement.
    idle(3, "prewrap");
    step(1'b0, 16'h0000, 1'b0, 1'b1, "pause_on_wrap");
    check("pause_wrap_dec.const", count, 16'h0047);
    check("pause_wrap_state.const", 16'(running), 16'h0000);
    step(1'b0, 16'h0000, 1'b1, 1'b0, "resume2");
    idle(4, "run_after_wrap");
    check("after_wrap.const", count, 16'h0046);

    // Digit clamping and load priority over start.
    step(1'b1, 16'hFA3C, 1'b0, 1'b0, "clamp");
    check("clamp.const", count, 16'h9939);
    step(1'b1, 16'hFA3C, 1'b1, 1'b0, "load_beats_start");
    check("load_prio.const", 16'(running), 16'h0000);
    step(1'b0, 16'h0000, 1'b1, 1'b1, "idle_pause_start");

    // Asynchronous reset between clock edges mid-RUN.
    step(1'b1, 16'h0100, 1'b0, 1'b0, "load_rst");
    step(1'b0, 16'h0000, 1'b1, 1'b0, "start_rst");
    idle(5, "run_rst");
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_model("async_reset");
    #1;
    reset_n = 1'b1;
    idle(2, "after_reset");

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic        le;
      logic [15:0] ld;
      logic        st;
      logic        ps;
      le = ($urandom_range(0, 99) < 3);
      ld = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 18));
      st = ($urandom_range(0, 99) < 40);
      ps = ($urandom_range(0, 99) < 8);
      step(le, ld, st, ps, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
